// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
//   Bundles the request/response signals of the two requesters (CPU and
//   loader) and the memory-side bus of the shared memory arbiter.
//
//   Parameters:
//     AW - address width
//     DW - data width
//
//   Signal groups:
//     cpu_*  - CPU request (req/we/addr/wdata) and response (rdata/ack/err)
//     ld_*   - loader/debug request and response, same shape as cpu_*
//     mem_*  - memory bus: en/we/addr/wdata driven by the arbiter,
//              rdata returned combinationally by the memory array
//
//   Modports:
//     slave  - the arbiter's view (takes requests, drives the memory bus)
//     master - the environment's view (requesters plus memory array)
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;
    logic          cpu_err;

    logic          ld_req;
    logic          ld_we;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic [DW-1:0] ld_rdata;
    logic          ld_ack;
    logic          ld_err;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack, cpu_err,
        input  ld_req, ld_we, ld_addr, ld_wdata,
        output ld_rdata, ld_ack, ld_err,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack, cpu_err,
        output ld_req, ld_we, ld_addr, ld_wdata,
        input  ld_rdata, ld_ack, ld_err,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Shares one unified instruction/data memory between the multicycle CPU
//   and a loader/debug port. Each access is latched at grant time, held on
//   the memory bus for WAIT_CYCLES cycles, then acknowledged to its owner
//   with a one-cycle ack. CPU has priority, but after MAX_CPU_BURST
//   consecutive CPU grants with the loader waiting, the loader wins once.
//
//   Ports:
//     clk    - system clock, rising edge
//     reset  - asynchronous, active-high reset
//     bus    - mem_arbiter_if.slave: cpu_*, ld_* request/response, mem_* bus
//     busy   - FSM is not in IDLE
//     owner  - 0 = CPU, 1 = loader; owner of the current/last grant
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int AW            = 16,
    parameter int DW            = 16,
    parameter int MEM_DEPTH     = 20,
    parameter int WAIT_CYCLES   = 1,
    parameter int MAX_CPU_BURST = 4
) (
    input  logic            clk,
    input  logic            reset,
    mem_arbiter_if.slave    bus,
    output logic            busy,
    output logic            owner
);

    localparam int SW = $clog2(MAX_CPU_BURST + 1);

    localparam logic [3:0]    WAIT_INIT = 4'(WAIT_CYCLES);
    localparam logic [SW-1:0] BURST_MAX = SW'(MAX_CPU_BURST);
    localparam logic [AW-1:0] DEPTH     = AW'(MEM_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t         state_reg, state_next;
    logic [3:0]     wcnt_reg, wcnt_next;
    logic [SW-1:0]  streak_reg, streak_next;
    logic           owner_reg, owner_next;
    logic           we_reg, we_next;
    logic           err_reg, err_next;
    logic [AW-1:0]  addr_reg, addr_next;
    logic [DW-1:0]  wdata_reg, wdata_next;
    logic [DW-1:0]  cpu_rdata_reg, cpu_rdata_next;
    logic [DW-1:0]  ld_rdata_reg, ld_rdata_next;

    // Arbitration terms, only meaningful while IDLE.
    logic           grant_ld;
    logic           grant_any;
    logic           sel_we;
    logic [AW-1:0]  sel_addr;
    logic [DW-1:0]  sel_wdata;

    always_comb begin
        grant_any = bus.cpu_req | bus.ld_req;
        // Loader wins when alone, or when the CPU has used up its burst.
        grant_ld  = bus.ld_req & (~bus.cpu_req | (streak_reg == BURST_MAX));
        sel_we    = grant_ld ? bus.ld_we    : bus.cpu_we;
        sel_addr  = grant_ld ? bus.ld_addr  : bus.cpu_addr;
        sel_wdata = grant_ld ? bus.ld_wdata : bus.cpu_wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            wcnt_reg      <= '0;
            streak_reg    <= '0;
            owner_reg     <= 1'b0;
            we_reg        <= 1'b0;
            err_reg       <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            cpu_rdata_reg <= '0;
            ld_rdata_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            wcnt_reg      <= wcnt_next;
            streak_reg    <= streak_next;
            owner_reg     <= owner_next;
            we_reg        <= we_next;
            err_reg       <= err_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            cpu_rdata_reg <= cpu_rdata_next;
            ld_rdata_reg  <= ld_rdata_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        wcnt_next      = wcnt_reg;
        streak_next    = streak_reg;
        owner_next     = owner_reg;
        we_next        = we_reg;
        err_next       = err_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        cpu_rdata_next = cpu_rdata_reg;
        ld_rdata_next  = ld_rdata_reg;

        unique case (state_reg)
            IDLE: begin
                if (grant_any) begin
                    owner_next = grant_ld;
                    we_next    = sel_we;
                    addr_next  = sel_addr;
                    wdata_next = sel_wdata;

                    // The streak only grows while the loader is actually
                    // being held off; any other grant restarts it.
                    if (grant_ld || !bus.ld_req) begin
                        streak_next = '0;
                    end else if (streak_reg != BURST_MAX) begin
                        streak_next = streak_reg + 1'b1;
                    end

                    if (sel_addr >= DEPTH) begin
                        // Out-of-range: never touch memory, report at once.
                        err_next   = 1'b1;
                        wcnt_next  = '0;
                        state_next = RESP;
                    end else begin
                        err_next   = 1'b0;
                        wcnt_next  = WAIT_INIT;
                        state_next = ACCESS;
                    end
                end
            end

            ACCESS: begin
                wcnt_next = wcnt_reg - 1'b1;
                if (wcnt_reg == 4'd1) begin
                    if (!we_reg) begin
                        if (owner_reg) begin
                            ld_rdata_next = bus.mem_rdata;
                        end else begin
                            cpu_rdata_next = bus.mem_rdata;
                        end
                    end
                    state_next = RESP;
                end
            end

            RESP: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Memory bus and responses decode straight from registered state so a
    // reset drops them in the same instant it clears the FSM.
    logic in_access;
    logic in_resp;
    logic no_data;

    always_comb begin
        in_access = (state_reg == ACCESS);
        in_resp   = (state_reg == RESP);
        // Writes and rejected accesses return zero on the ack cycle; the
        // captured read value is left untouched for later inspection.
        no_data   = in_resp & (we_reg | err_reg);
    end

    assign bus.mem_en    = in_access;
    assign bus.mem_we    = in_access & we_reg & (wcnt_reg == 4'd1);
    assign bus.mem_addr  = in_access ? addr_reg  : '0;
    assign bus.mem_wdata = in_access ? wdata_reg : '0;

    assign bus.cpu_ack   = in_resp & ~owner_reg;
    assign bus.cpu_err   = in_resp & ~owner_reg & err_reg;
    assign bus.cpu_rdata = (no_data & ~owner_reg) ? '0 : cpu_rdata_reg;

    assign bus.ld_ack    = in_resp & owner_reg;
    assign bus.ld_err    = in_resp & owner_reg & err_reg;
    assign bus.ld_rdata  = (no_data & owner_reg) ? '0 : ld_rdata_reg;

    assign busy  = (state_reg != IDLE);
    assign owner = owner_reg;

endmodule
